// File: rtl/mux_pkg.sv
// Shared types for the N-channel registered mux: output-stage state, mode encodings,
// and modular channel-index increment used by the round-robin pointer.
package mux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Next channel index after ch, wrapping n_ch-1 back to 0.
  function automatic int ch_inc(input int ch, input int n_ch);
    return (ch >= n_ch - 1) ? 0 : ch + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr_i wins, else
// lowest requester below ptr_i. Zero latency; no state, the caller owns the pointer.
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [N_CH-1:0]  gnt_oh_o,
  output logic [SEL_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  int ptr_int;

  assign ptr_int = int'(ptr_i);

  // Two ascending passes: first the upper segment [ptr, N_CH), then the wrapped
  // lower segment [0, ptr). The first hit across both passes is the grant.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!gnt_vld_o && req_i[k] && (k >= ptr_int)) begin
        gnt_vld_o   = 1'b1;
        gnt_oh_o[k] = 1'b1;
        gnt_idx_o   = SEL_W'(k);
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      if (!gnt_vld_o && req_i[k] && (k < ptr_int)) begin
        gnt_vld_o   = 1'b1;
        gnt_oh_o[k] = 1'b1;
        gnt_idx_o   = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux_nch_rr.sv
// N-channel valid/ready mux into one output register (1-cycle latency, 1 word/cycle); a held word
// stalls all inputs until out_ready. Round-robin mode compiled in only with MUX_RR_EN, else manual only.
module mux_nch_rr
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e           state_q;
  logic [W-1:0]     data_q;
  logic [SEL_W-1:0] ch_q;

  logic [N_CH-1:0]  man_oh;
  logic [SEL_W-1:0] man_idx;
  logic             man_vld;

  logic [N_CH-1:0]  gnt_oh;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic [W-1:0]     gnt_dat;

  logic             can_load;
  logic             xfer;

  // Matching sel against each legal index keeps out-of-range selects grant-free.
  always_comb begin
    man_oh  = '0;
    man_idx = '0;
    man_vld = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if ((sel == SEL_W'(k)) && in_valid[k]) begin
        man_oh[k] = 1'b1;
        man_idx   = SEL_W'(k);
        man_vld   = 1'b1;
      end
    end
  end

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [N_CH-1:0]  rr_oh;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_vld;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .req_i     (in_valid),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (rr_oh),
    .gnt_idx_o (rr_idx),
    .gnt_vld_o (rr_vld)
  );

  always_comb begin
    if (mode == MODE_RR) begin
      gnt_oh  = rr_oh;
      gnt_idx = rr_idx;
      gnt_vld = rr_vld;
    end else begin
      gnt_oh  = man_oh;
      gnt_idx = man_idx;
      gnt_vld = man_vld;
    end
  end

  // Pointer moves past the winner only on round-robin transfers.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && (mode == MODE_RR)) begin
      ptr_d = SEL_W'(ch_inc(int'(gnt_idx), N_CH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic mode_unused;

  assign mode_unused = mode;
  assign gnt_oh      = man_oh;
  assign gnt_idx     = man_idx;
  assign gnt_vld     = man_vld;
`endif

  always_comb begin
    gnt_dat = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_oh[k]) begin
        gnt_dat = in_data[k*W +: W];
      end
    end
  end

  assign can_load = (state_q == ST_EMPTY) || out_ready;
  assign xfer     = !rst && can_load && gnt_vld;
  assign in_ready = (!rst && can_load) ? gnt_oh : '0;

  // A drained register keeps its stale data/ch; only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
    end else if (xfer) begin
      state_q <= ST_FULL;
      data_q  <= gnt_dat;
      ch_q    <= gnt_idx;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_q <= ST_EMPTY;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule
